// File: rtl/dram_cmd_responder.sv
// dram_cmd_responder
//   Device-side model of a DRAM command path. Accepts one PRE/ACT/RD/WR per
//   cycle, tracks a row state machine per bank ({bg,bank}), enforces tRCD/tRP,
//   stores write data and returns read data T_CL cycles after the read.
//   Illegal commands are dropped and reported on the error port next cycle.
//
// Build option:
//   AUTO_PRECHARGE_EN - when defined, a legal RD/WR with cmd_ap_in=1 moves its
//                       bank straight to PRECHARGING after the access.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-low reset
//   cmd_valid_in/ready_out  command handshake (no backpressure once out of reset)
//   cmd_op_in               00 PRE, 01 ACT, 10 RD, 11 WR
//   cmd_bg/bank/row/col_in  command address
//   cmd_wdata_in            write data, cmd_ap_in auto-precharge request
//   rsp_*_out               read response (single-cycle valid pulse)
//   err_valid/code_out      001 ACT to non-IDLE, 010 RD/WR to non-ACTIVE,
//                           011 RD/WR row mismatch, 100 PRE while busy
//
// Bank FSM:
//   state          | meaning
//   ST_IDLE        | no open row, ACT allowed
//   ST_ACTIVATING  | row opening, counting down tRCD
//   ST_ACTIVE      | row open, RD/WR/PRE allowed
//   ST_PRECHARGING | row closing, counting down tRP
module dram_cmd_responder #(
    parameter int BG_WIDTH   = 3,
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH  = 8,
    parameter int COL_WIDTH  = 8,
    parameter int DATA_WIDTH = 64,
    parameter int T_RCD      = 3,
    parameter int T_RP       = 3,
    parameter int T_CL       = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    input  logic [1:0]            cmd_op_in,
    input  logic [BG_WIDTH-1:0]   cmd_bg_in,
    input  logic [BANK_WIDTH-1:0] cmd_bank_in,
    input  logic [ROW_WIDTH-1:0]  cmd_row_in,
    input  logic [COL_WIDTH-1:0]  cmd_col_in,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_in,
    input  logic                  cmd_ap_in,
    output logic                  rsp_valid_out,
    output logic [DATA_WIDTH-1:0] rsp_data_out,
    output logic [BG_WIDTH-1:0]   rsp_bg_out,
    output logic [BANK_WIDTH-1:0] rsp_bank_out,
    output logic [COL_WIDTH-1:0]  rsp_col_out,
    output logic                  err_valid_out,
    output logic [2:0]            err_code_out
);

    localparam int BIDX_W    = BG_WIDTH + BANK_WIDTH;
    localparam int NUM_BANKS = 1 << BIDX_W;
    localparam int MEM_DEPTH = 1 << (BIDX_W + COL_WIDTH);
    localparam int T_MAX     = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W     = $clog2(T_MAX + 1);

`ifdef AUTO_PRECHARGE_EN
    localparam bit AP_EN = 1'b1;
`else
    localparam bit AP_EN = 1'b0;
`endif

    localparam logic [1:0] OP_PRE = 2'b00;
    localparam logic [1:0] OP_ACT = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_WR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVATING,
        ST_ACTIVE,
        ST_PRECHARGING
    } bank_st_e;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic [BG_WIDTH-1:0]   bg;
        logic [BANK_WIDTH-1:0] bank;
        logic [COL_WIDTH-1:0]  col;
    } rsp_t;

    // A one-cycle timing skips the wait state entirely.
    localparam bank_st_e ACT_NEXT = (T_RCD == 1) ? ST_ACTIVE : ST_ACTIVATING;
    localparam bank_st_e PRE_NEXT = (T_RP == 1) ? ST_IDLE : ST_PRECHARGING;
    localparam logic [CNT_W-1:0] CNT_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] CNT_RP  = CNT_W'(T_RP - 1);

    bank_st_e               st_q  [NUM_BANKS];
    bank_st_e               st_d  [NUM_BANKS];
    logic [CNT_W-1:0]       cnt_q [NUM_BANKS];
    logic [CNT_W-1:0]       cnt_d [NUM_BANKS];
    logic [ROW_WIDTH-1:0]   row_q [NUM_BANKS];
    logic [ROW_WIDTH-1:0]   row_d [NUM_BANKS];
    rsp_t                   pipe_q [T_CL];
    rsp_t                   pipe_d [T_CL];
    logic                   ready_q;
    logic                   err_valid_q, err_valid_d;
    logic [2:0]             err_code_q, err_code_d;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                   accept;
    logic                   rd_ok;
    logic                   wr_ok;
    logic [BIDX_W-1:0]      bidx;
    logic [BIDX_W+COL_WIDTH-1:0] maddr;

    assign accept = cmd_valid_in & ready_q;
    assign bidx   = {cmd_bg_in, cmd_bank_in};
    assign maddr  = {bidx, cmd_col_in};

    always_comb begin
        // Countdowns leave the wait state on the edge where they reach zero,
        // so an ACT at cycle t makes the bank usable in cycle t+T_RCD.
        for (int b = 0; b < NUM_BANKS; b++) begin
            st_d[b]  = st_q[b];
            cnt_d[b] = cnt_q[b];
            row_d[b] = row_q[b];
            if (st_q[b] == ST_ACTIVATING || st_q[b] == ST_PRECHARGING) begin
                if (cnt_q[b] <= CNT_W'(1)) begin
                    st_d[b]  = (st_q[b] == ST_ACTIVATING) ? ST_ACTIVE : ST_IDLE;
                    cnt_d[b] = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] - CNT_W'(1);
                end
            end
        end

        err_valid_d = 1'b0;
        err_code_d  = 3'b000;
        rd_ok       = 1'b0;
        wr_ok       = 1'b0;

        if (accept) begin
            case (cmd_op_in)
                OP_PRE: begin
                    if (st_q[bidx] == ST_ACTIVE) begin
                        st_d[bidx]  = PRE_NEXT;
                        cnt_d[bidx] = CNT_RP;
                    end else if (st_q[bidx] != ST_IDLE) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'b100;
                    end
                end
                OP_ACT: begin
                    if (st_q[bidx] != ST_IDLE) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'b001;
                    end else begin
                        st_d[bidx]  = ACT_NEXT;
                        cnt_d[bidx] = CNT_RCD;
                        row_d[bidx] = cmd_row_in;
                    end
                end
                default: begin
                    if (st_q[bidx] != ST_ACTIVE) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'b010;
                    end else if (cmd_row_in != row_q[bidx]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'b011;
                    end else begin
                        rd_ok = (cmd_op_in == OP_RD);
                        wr_ok = (cmd_op_in == OP_WR);
                        if (AP_EN && cmd_ap_in) begin
                            st_d[bidx]  = PRE_NEXT;
                            cnt_d[bidx] = CNT_RP;
                        end
                    end
                end
            endcase
        end

        // Storage is sampled at the accept edge, so a later WR to the same
        // address cannot change a read already in flight.
        pipe_d[0] = '0;
        if (rd_ok) begin
            pipe_d[0] = '{valid: 1'b1, data: mem[maddr], bg: cmd_bg_in,
                          bank: cmd_bank_in, col: cmd_col_in};
        end
        for (int i = 1; i < T_CL; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                st_q[b]  <= ST_IDLE;
                cnt_q[b] <= '0;
                row_q[b] <= '0;
            end
            for (int i = 0; i < T_CL; i++) begin
                pipe_q[i] <= '0;
            end
            ready_q     <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 3'b000;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                st_q[b]  <= st_d[b];
                cnt_q[b] <= cnt_d[b];
                row_q[b] <= row_d[b];
            end
            for (int i = 0; i < T_CL; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            ready_q     <= 1'b1;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (wr_ok) begin
            mem[maddr] <= cmd_wdata_in;
        end
    end

    assign cmd_ready_out = ready_q;
    assign rsp_valid_out = pipe_q[T_CL-1].valid;
    assign rsp_data_out  = pipe_q[T_CL-1].data;
    assign rsp_bg_out    = pipe_q[T_CL-1].bg;
    assign rsp_bank_out  = pipe_q[T_CL-1].bank;
    assign rsp_col_out   = pipe_q[T_CL-1].col;
    assign err_valid_out = err_valid_q;
    assign err_code_out  = err_code_q;

endmodule

// File: tb/tb_dram_cmd_responder.sv
module tb_dram_cmd_responder;
    localparam int BGW = 3, BKW = 3, RW = 8, CW = 8, DW = 64;
    localparam int T_RCD = 3, T_RP = 3, T_CL = 5;
`ifdef AUTO_PRECHARGE_EN
    localparam bit AP_EN = 1'b1;
`else
    localparam bit AP_EN = 1'b0;
`endif
    localparam logic [1:0] PRE = 2'b00, ACT = 2'b01, RD = 2'b10, WR = 2'b11;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           cmd_valid_in;
    logic           cmd_ready_out;
    logic [1:0]     cmd_op_in;
    logic [BGW-1:0] cmd_bg_in;
    logic [BKW-1:0] cmd_bank_in;
    logic [RW-1:0]  cmd_row_in;
    logic [CW-1:0]  cmd_col_in;
    logic [DW-1:0]  cmd_wdata_in;
    logic           cmd_ap_in;
    logic           rsp_valid_out;
    logic [DW-1:0]  rsp_data_out;
    logic [BGW-1:0] rsp_bg_out;
    logic [BKW-1:0] rsp_bank_out;
    logic [CW-1:0]  rsp_col_out;
    logic           err_valid_out;
    logic [2:0]     err_code_out;

    dram_cmd_responder #(
        .BG_WIDTH(BGW), .BANK_WIDTH(BKW), .ROW_WIDTH(RW), .COL_WIDTH(CW),
        .DATA_WIDTH(DW), .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_op_in(cmd_op_in), .cmd_bg_in(cmd_bg_in), .cmd_bank_in(cmd_bank_in),
        .cmd_row_in(cmd_row_in), .cmd_col_in(cmd_col_in),
        .cmd_wdata_in(cmd_wdata_in), .cmd_ap_in(cmd_ap_in),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
        .rsp_bg_out(rsp_bg_out), .rsp_bank_out(rsp_bank_out),
        .rsp_col_out(rsp_col_out),
        .err_valid_out(err_valid_out), .err_code_out(err_code_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: banks are described by event times, not counters.
    // A bank is ACTIVE once T_RCD cycles have passed since its ACT, and is
    // PRECHARGING until T_RP cycles after its PRE.
    typedef struct {
        int            due;
        bit            known;
        logic [63:0]   d;
        int            bg;
        int            bank;
        int            col;
    } exp_rsp_t;

    bit          m_open [64];
    int          m_row  [64];
    int          m_tact [64];
    int          m_tpre [64];
    logic [63:0] m_mem  [int];
    exp_rsp_t    rq [$];
    int          err_due = -1;
    logic [2:0]  err_exp = 3'b000;

    localparam int S_IDLE = 0, S_OPENING = 1, S_OPEN = 2, S_CLOSING = 3;

    function automatic int bank_status(input int b);
        if (m_open[b]) return (cyc >= m_tact[b] + T_RCD) ? S_OPEN : S_OPENING;
        return (cyc < m_tpre[b]) ? S_CLOSING : S_IDLE;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 64; b++) begin
            m_open[b] = 1'b0;
            m_tpre[b] = 0;
        end
        rq.delete();
        err_due = -1;
    endtask

    task automatic model_check();
        exp_rsp_t r;
        bit ev;
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        chk("cmd_ready", cmd_ready_out, 1'b1);
        chk("rsp_valid", rsp_valid_out, ev);
        if (ev) begin
            r = rq.pop_front();
            if (r.known) chk("rsp_data", rsp_data_out, r.d);
            chk("rsp_bg", rsp_bg_out, r.bg);
            chk("rsp_bank", rsp_bank_out, r.bank);
            chk("rsp_col", rsp_col_out, r.col);
        end
        chk("err_valid", err_valid_out, err_due == cyc);
        if (err_due == cyc) chk("err_code", err_code_out, err_exp);
    endtask

    task automatic model_cmd(input bit v, input logic [1:0] op, input int bg, input int bank,
                             input int row, input int col, input logic [63:0] wd, input bit ap);
        exp_rsp_t r;
        int b, st, code, addr;
        if (!v) return;
        b    = bg * 8 + bank;
        st   = bank_status(b);
        code = 0;
        addr = b * 256 + col;
        case (op)
            PRE: begin
                if (st == S_OPEN) begin
                    m_open[b] = 1'b0;
                    m_tpre[b] = cyc + T_RP;
                end else if (st != S_IDLE) code = 4;
            end
            ACT: begin
                if (st != S_IDLE) code = 1;
                else begin
                    m_open[b] = 1'b1;
                    m_row[b]  = row;
                    m_tact[b] = cyc;
                end
            end
            default: begin
                if (st != S_OPEN) code = 2;
                else if (row != m_row[b]) code = 3;
                else begin
                    if (op == WR) m_mem[addr] = wd;
                    else begin
                        r.due   = cyc + T_CL;
                        r.known = m_mem.exists(addr);
                        r.d     = r.known ? m_mem[addr] : 64'h0;
                        r.bg    = bg;
                        r.bank  = bank;
                        r.col   = col;
                        rq.push_back(r);
                    end
                    if (AP_EN && ap) begin
                        m_open[b] = 1'b0;
                        m_tpre[b] = cyc + T_RP;
                    end
                end
            end
        endcase
        if (code != 0) begin
            err_due = cyc + 1;
            err_exp = 3'(code);
        end
    endtask

    // One cycle: check outputs for this cycle, drive this cycle's command,
    // advance the model, then move to the next sampling point.
    task automatic step(input bit v, input logic [1:0] op, input int bg, input int bank,
                        input int row, input int col, input logic [63:0] wd, input bit ap);
        model_check();
        cmd_valid_in = v;
        cmd_op_in    = op;
        cmd_bg_in    = BGW'(bg);
        cmd_bank_in  = BKW'(bank);
        cmd_row_in   = RW'(row);
        cmd_col_in   = CW'(col);
        cmd_wdata_in = wd;
        cmd_ap_in    = ap;
        model_cmd(v, op, bg, bank, row, col, wd, ap);
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(1'b0, PRE, 0, 0, 0, 0, 64'h0, 1'b0);
    endtask

    // Directed vectors: command for this cycle plus the outputs expected
    // at the sampling point of the same cycle.
    typedef struct {
        bit          v;
        logic [1:0]  op;
        int          bg, bank, row, col;
        logic [63:0] wd;
        bit          e_rv;
        int          e_col;
        bit          e_dchk;
        logic [63:0] e_rd;
        bit          e_ev;
        logic [2:0]  e_ec;
    } vec_t;

    vec_t vt [$];

    task automatic add(input bit v, input logic [1:0] op, input int bg, input int bank,
                       input int row, input int col, input logic [63:0] wd,
                       input bit e_rv, input int e_col, input bit e_dchk, input logic [63:0] e_rd,
                       input bit e_ev, input logic [2:0] e_ec);
        vec_t x;
        x.v = v; x.op = op; x.bg = bg; x.bank = bank; x.row = row; x.col = col; x.wd = wd;
        x.e_rv = e_rv; x.e_col = e_col; x.e_dchk = e_dchk; x.e_rd = e_rd;
        x.e_ev = e_ev; x.e_ec = e_ec;
        vt.push_back(x);
    endtask

    task automatic add_nops(input int n);
        for (int i = 0; i < n; i++) add(0, PRE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] wd;
        int t;

        // read after write (t=0..9)
        add(1, ACT, 0, 0, 'h12, 0, 0,                    0, 0, 0, 0, 0, 0);
        add_nops(2);
        add(1, WR,  0, 0, 'h12, 4, 64'hDEADBEEFCAFEBABE, 0, 0, 0, 0, 0, 0);
        add(1, RD,  0, 0, 'h12, 4, 0,                    0, 0, 0, 0, 0, 0);
        add_nops(4);
        add(0, PRE, 0, 0, 0, 0, 0,   1, 4, 1, 64'hDEADBEEFCAFEBABE, 0, 0);
        // early read and row mismatch (t=10..18)
        add(1, ACT, 1, 2, 5, 0, 0,   0, 0, 0, 0, 0, 0);
        add_nops(1);
        add(1, RD,  1, 2, 5, 9, 0,   0, 0, 0, 0, 0, 0);
        add(1, RD,  1, 2, 5, 9, 0,   0, 0, 0, 0, 1, 3'b010);
        add_nops(1);
        add(1, RD,  1, 2, 6, 9, 0,   0, 0, 0, 0, 0, 0);
        add(0, PRE, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3'b011);
        add_nops(1);
        add(0, PRE, 0, 0, 0, 0, 0,   1, 9, 0, 0, 0, 0);
        // activate / precharge timing (t=19..25)
        add(1, ACT, 0, 0, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        add(1, PRE, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3'b001);
        add_nops(1);
        add(1, ACT, 0, 0, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        add(1, ACT, 0, 0, 3, 0, 0,   0, 0, 0, 0, 1, 3'b001);
        add(1, PRE, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, PRE, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3'b100);
        // pipelined reads with a write behind them (t=26..44)
        for (int c = 0; c < 4; c++) add(1, WR, 0, 0, 3, c, 64'hA0 + c, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) add(1, RD, 0, 0, 3, c, 0,          0, 0, 0, 0, 0, 0);
        add(1, WR, 0, 0, 3, 1, 64'hB1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) add(0, PRE, 0, 0, 0, 0, 0, 1, c, 1, 64'hA0 + c, 0, 0);
        add(1, RD, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        add_nops(4);
        add(0, PRE, 0, 0, 0, 0, 0,   1, 1, 1, 64'hB1, 0, 0);

        cmd_valid_in = 1'b0; cmd_op_in = PRE; cmd_bg_in = '0; cmd_bank_in = '0;
        cmd_row_in = '0; cmd_col_in = '0; cmd_wdata_in = '0; cmd_ap_in = 1'b0;
        rst_in = 1'b1;
        #2 rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("reset_rsp_valid", rsp_valid_out, 1'b0);
        chk("reset_rsp_data", rsp_data_out, 64'h0);
        chk("reset_rsp_col", rsp_col_out, 0);
        chk("reset_err_valid", err_valid_out, 1'b0);
        chk("reset_err_code", err_code_out, 3'b000);
        chk("reset_ready", cmd_ready_out, 1'b0);
        rst_in = 1'b1;
        #1 chk("ready_before_first_edge", cmd_ready_out, 1'b0);
        @(negedge clk_in);
        model_reset();
        cyc = 0;

        foreach (vt[i]) begin
            chk($sformatf("vec%0d_rsp_valid", i), rsp_valid_out, vt[i].e_rv);
            if (vt[i].e_rv) begin
                chk($sformatf("vec%0d_rsp_col", i), rsp_col_out, vt[i].e_col);
                if (vt[i].e_dchk) chk($sformatf("vec%0d_rsp_data", i), rsp_data_out, vt[i].e_rd);
            end
            chk($sformatf("vec%0d_err_valid", i), err_valid_out, vt[i].e_ev);
            if (vt[i].e_ev) chk($sformatf("vec%0d_err_code", i), err_code_out, vt[i].e_ec);
            step(vt[i].v, vt[i].op, vt[i].bg, vt[i].bank, vt[i].row, vt[i].col, vt[i].wd, 1'b0);
        end

        // reset with reads in flight: bank 0/0 is ACTIVE on row 3
        for (int c = 0; c < 4; c++) step(1'b1, RD, 0, 0, 3, c, 64'h0, 1'b0);
        step(1'b1, WR, 0, 0, 3, 1, 64'hC1, 1'b0);
        nop(1);
        model_check();
        rst_in = 1'b0;
        #1;
        chk("midreset_rsp_valid", rsp_valid_out, 1'b0);
        chk("midreset_rsp_data", rsp_data_out, 64'h0);
        chk("midreset_ready", cmd_ready_out, 1'b0);
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        cyc += 4;
        nop(8);

        // storage survives reset; the row is not part of the storage index
        step(1'b1, ACT, 0, 0, 7, 0, 64'h0, 1'b0);
        nop(2);
        step(1'b1, RD, 0, 0, 7, 1, 64'h0, 1'b0);
        nop(4);
        chk("mem_survives_reset_valid", rsp_valid_out, 1'b1);
        chk("mem_survives_reset_data", rsp_data_out, 64'hC1);
        nop(2);

        // auto-precharge
        step(1'b1, ACT, 2, 3, 1, 0, 64'h0, 1'b0);
        nop(2);
        step(1'b1, WR, 2, 3, 1, 5, 64'h55, 1'b0);
        t = cyc;
        step(1'b1, RD, 2, 3, 1, 5, 64'h0, 1'b1);
        nop(1);
        step(1'b1, ACT, 2, 3, 2, 0, 64'h0, 1'b0);
        chk("ap_act_t2_err_valid", err_valid_out, 1'b1);
        chk("ap_act_t2_err_code", err_code_out, 3'b001);
        step(1'b1, ACT, 2, 3, 2, 0, 64'h0, 1'b0);
        chk("ap_act_t3_err_valid", err_valid_out, !AP_EN);
        chk("ap_rsp_cycle", cyc + 1, t + T_CL);
        nop(8);

        // randomized traffic on a few banks
        for (int i = 0; i < 600; i++) begin
            wd = {$urandom, $urandom};
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2),
                 $urandom_range(0, 3), wd, $urandom_range(0, 3) == 0);
        end
        nop(T_CL + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
